// File: rtl/sr_target_emu.sv
// Chip-side emulator of the TMIIa configuration shift register: synchronised serial shift-in,
// registered readback and load-latched config. Optional preload port via SR_TARGET_EMU_PRELOAD_EN.
module sr_target_emu #(
  parameter int WIDTH           = 170,
  parameter int CNT_WIDTH       = 8,
  parameter int SHIFT_DIRECTION = 1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_sr,
  input  logic                 data_in,
  input  logic                 load_sr,
`ifdef SR_TARGET_EMU_PRELOAD_EN
  input  logic [WIDTH-1:0]     preload,
  input  logic                 preload_stb,
`endif
  output logic                 data_out,
  output logic [WIDTH-1:0]     cfg,
  output logic                 cfg_valid,
  output logic [CNT_WIDTH-1:0] bit_cnt,
  output logic                 err_len
);

  typedef enum logic [1:0] {IDLE, SHIFTING, LATCH} state_t;

  localparam logic [CNT_WIDTH-1:0] WIDTH_CNT = CNT_WIDTH'(WIDTH);

  logic [SYNC_STAGES-1:0] clk_sr_sync_q, data_sync_q, load_sync_q;
  logic                   clk_sr_prev_q, load_prev_q;
  logic                   clk_sr_s, data_s, load_s;
  logic                   shift_ev, load_ev;

  logic [WIDTH-1:0]       sr_q, sr_d, sr_shifted;
  logic [WIDTH-1:0]       cfg_q, cfg_d;
  logic                   sr_exit, data_out_q;
  logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d, cnt_after_shift;
  logic                   err_len_q, err_len_d;
  state_t                 state_q, state_d;

  // All three lines use the same depth so data stays aligned with its clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr_sync_q <= '0;
      data_sync_q   <= '0;
      load_sync_q   <= '0;
      clk_sr_prev_q <= 1'b0;
      load_prev_q   <= 1'b0;
    end else begin
      clk_sr_sync_q <= {clk_sr_sync_q[SYNC_STAGES-2:0], clk_sr};
      data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], data_in};
      load_sync_q   <= {load_sync_q[SYNC_STAGES-2:0], load_sr};
      clk_sr_prev_q <= clk_sr_s;
      load_prev_q   <= load_s;
    end
  end

  assign clk_sr_s = clk_sr_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign load_s   = load_sync_q[SYNC_STAGES-1];
  assign shift_ev = clk_sr_s & ~clk_sr_prev_q;
  assign load_ev  = load_s & ~load_prev_q;

  generate
    if (SHIFT_DIRECTION != 0) begin : g_msb_out
      assign sr_shifted = {sr_q[WIDTH-2:0], data_s};
      assign sr_exit    = sr_q[WIDTH-1];
    end else begin : g_lsb_out
      assign sr_shifted = {data_s, sr_q[WIDTH-1:1]};
      assign sr_exit    = sr_q[0];
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (shift_ev) begin
      sr_d = sr_shifted;
`ifdef SR_TARGET_EMU_PRELOAD_EN
    end else if (preload_stb && !load_ev) begin
      sr_d = preload;
`endif
    end
  end

  // A coincident shift counts toward the frame length before the load checks it.
  always_comb begin
    cnt_after_shift = bit_cnt_q;
    if (shift_ev && (bit_cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_after_shift = bit_cnt_q + 1'b1;
    end
    bit_cnt_d = cnt_after_shift;
    err_len_d = err_len_q;
    cfg_d     = cfg_q;
    if (load_ev) begin
      bit_cnt_d = '0;
      err_len_d = (cnt_after_shift != WIDTH_CNT);
      cfg_d     = sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_ev) begin
      state_d = LATCH;
    end else if (shift_ev) begin
      state_d = SHIFTING;
    end else if (state_q == LATCH) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      cfg_q      <= '0;
      data_out_q <= 1'b0;
      bit_cnt_q  <= '0;
      err_len_q  <= 1'b0;
      state_q    <= IDLE;
    end else begin
      sr_q       <= sr_d;
      cfg_q      <= cfg_d;
      data_out_q <= sr_exit;
      bit_cnt_q  <= bit_cnt_d;
      err_len_q  <= err_len_d;
      state_q    <= state_d;
    end
  end

  assign data_out  = data_out_q;
  assign cfg       = cfg_q;
  assign cfg_valid = (state_q == LATCH);
  assign bit_cnt   = bit_cnt_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_sr_target_emu.sv
// Drives two emulators (MSB-out with a 4-bit counter, LSB-out with an 8-bit counter) from
// one serial stream and compares both against a bit-level model of the register.
module tb_sr_target_emu;
  localparam int W = 8;

  logic clk = 1'b0, rst = 1'b1, clk_sr = 1'b0, data_in = 1'b0, load_sr = 1'b0;
`ifdef SR_TARGET_EMU_PRELOAD_EN
  logic [W-1:0] preload = '0;
  logic         preload_stb = 1'b0;
`endif
  logic         do1, do0, cv1, cv0, err1, err0;
  logic [W-1:0] cfg1, cfg0;
  logic [3:0]   cnt1;
  logic [7:0]   cnt0;

  int checks = 0, errors = 0;

  logic [W-1:0] m_sr1, m_sr0, m_cfg1, m_cfg0;
  int           m_cnt1, m_cnt0;
  logic         m_err1, m_err0;
  logic [31:0]  stream;

  sr_target_emu #(.WIDTH(W), .CNT_WIDTH(4), .SHIFT_DIRECTION(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .rst(rst), .clk_sr(clk_sr), .data_in(data_in), .load_sr(load_sr),
`ifdef SR_TARGET_EMU_PRELOAD_EN
    .preload(preload), .preload_stb(preload_stb),
`endif
    .data_out(do1), .cfg(cfg1), .cfg_valid(cv1), .bit_cnt(cnt1), .err_len(err1));

  sr_target_emu #(.WIDTH(W), .CNT_WIDTH(8), .SHIFT_DIRECTION(0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst(rst), .clk_sr(clk_sr), .data_in(data_in), .load_sr(load_sr),
`ifdef SR_TARGET_EMU_PRELOAD_EN
    .preload(preload), .preload_stb(preload_stb),
`endif
    .data_out(do0), .cfg(cfg0), .cfg_valid(cv0), .bit_cnt(cnt0), .err_len(err0));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sr1 = '0; m_sr0 = '0; m_cfg1 = '0; m_cfg0 = '0;
    m_cnt1 = 0; m_cnt0 = 0; m_err1 = 1'b0; m_err0 = 1'b0;
  endtask

  // Newest bit at LSB (MSB leaves first) vs newest bit at MSB (LSB leaves first).
  task automatic model_shift(input logic b);
    m_sr1 = W'((m_sr1 * 2) + b);
    m_sr0 = W'((m_sr0 / 2) + (b ? (1 << (W - 1)) : 0));
    m_cnt1 = (m_cnt1 >= 15) ? 15 : m_cnt1 + 1;
    m_cnt0 = (m_cnt0 >= 255) ? 255 : m_cnt0 + 1;
  endtask

  task automatic model_load();
    m_err1 = (m_cnt1 != W); m_err0 = (m_cnt0 != W);
    m_cfg1 = m_sr1; m_cfg0 = m_sr0;
    m_cnt1 = 0; m_cnt0 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_do1"}, 32'(do1), 32'(m_sr1[W-1]));
    chk({tag, "_do0"}, 32'(do0), 32'(m_sr0[0]));
    chk({tag, "_cfg1"}, 32'(cfg1), 32'(m_cfg1));
    chk({tag, "_cfg0"}, 32'(cfg0), 32'(m_cfg0));
    chk({tag, "_cnt1"}, 32'(cnt1), 32'(m_cnt1));
    chk({tag, "_cnt0"}, 32'(cnt0), 32'(m_cnt0));
    chk({tag, "_err1"}, 32'(err1), 32'(m_err1));
    chk({tag, "_err0"}, 32'(err0), 32'(m_err0));
  endtask

  task automatic shift_bit(input logic b, output logic seen1);
    chk("readback_dir1", 32'(do1), 32'(m_sr1[W-1]));
    chk("readback_dir0", 32'(do0), 32'(m_sr0[0]));
    seen1 = do1;
    data_in = b; clk_sr = 1'b0;
    tick(4);
    clk_sr = 1'b1;
    tick(4);
    clk_sr = 1'b0;
    model_shift(b);
    chk("shift_cnt1", 32'(cnt1), 32'(m_cnt1));
    chk("shift_cnt0", 32'(cnt0), 32'(m_cnt0));
  endtask

  task automatic shift_frame(input logic [31:0] val, input int n);
    logic s;
    stream = '0;
    for (int i = n - 1; i >= 0; i--) begin
      shift_bit(val[i], s);
      stream = {stream[30:0], s};
    end
  endtask

  task automatic do_load(input logic with_shift, input logic b);
    int v1, v0;
    v1 = 0; v0 = 0;
    data_in = b; clk_sr = 1'b0;
    tick(4);
    clk_sr = with_shift;
    load_sr = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      v1 += int'(cv1); v0 += int'(cv0);
    end
    load_sr = 1'b0; clk_sr = 1'b0;
    tick(4);
    if (with_shift) model_shift(b);
    model_load();
    chk("cfg_valid_cycles1", 32'(v1), 32'd1);
    chk("cfg_valid_cycles0", 32'(v0), 32'd1);
    check_all("load");
  endtask

  initial begin
    model_reset();
    tick(3);
    check_all("reset");
    chk("reset_cv1", 32'(cv1), 32'd0);
    chk("reset_cv0", 32'(cv0), 32'd0);
    rst = 1'b0;
    tick(2);

    shift_frame(32'hA5, 8);
    do_load(1'b0, 1'b0);
    chk("frame_a5_cfg1", 32'(cfg1), 32'hA5);

    shift_frame(32'h3C, 8);
    chk("readback_a5_stream", stream, 32'hA5);
    do_load(1'b0, 1'b0);
    chk("frame_3c_cfg1", 32'(cfg1), 32'h3C);

    shift_frame(32'h81, 8);
    do_load(1'b0, 1'b0);
    chk("frame_81_cfg0", 32'(cfg0), 32'h81);
    shift_frame(32'h00, 8);
    do_load(1'b0, 1'b0);

    shift_frame(32'h15, 5);
    do_load(1'b0, 1'b0);
    chk("short_err1", 32'(err1), 32'd1);
    shift_frame(32'h6B, 8);
    do_load(1'b0, 1'b0);
    chk("full_err1", 32'(err1), 32'd0);

    // Eighth bit arrives on the same edge as the load strobe.
    shift_frame(32'h5A, 7);
    do_load(1'b1, 1'b1);
    chk("simul_err1", 32'(err1), 32'd0);

    shift_frame($urandom, 20);
    chk("sat_cnt1", 32'(cnt1), 32'd15);
    chk("sat_cnt0", 32'(cnt0), 32'd20);
    do_load(1'b0, 1'b0);

    shift_frame(32'hF, 4);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("midreset");
    tick(1);
    rst = 1'b0;
    tick(2);
    shift_frame(32'hC9, 8);
    do_load(1'b0, 1'b0);
    chk("after_reset_cfg1", 32'(cfg1), 32'hC9);

    for (int f = 0; f < 8; f++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : W;
      shift_frame($urandom, n);
      do_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef SR_TARGET_EMU_PRELOAD_EN
    preload = 8'hC3; preload_stb = 1'b1;
    tick(1);
    preload_stb = 1'b0;
    tick(1);
    m_sr1 = 8'hC3; m_sr0 = 8'hC3;
    chk("preload_do1", 32'(do1), 32'd1);
    chk("preload_do0", 32'(do0), 32'd1);
    shift_frame(32'h00, 8);
    chk("preload_stream", stream, 32'hC3);
    do_load(1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
